// File: rtl/pkt_test_sequencer_pkg.sv
// Shared types and constants for the packet test sequencer and its response tracker.
package pkt_test_sequencer_pkg;

    localparam int MAX_PKT_DEF = 256;
    localparam int ERR_SAT     = 511;
    localparam int CNT_W       = 9;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    function automatic cnt_t clamp_cnt(input cnt_t n, input cnt_t limit);
        return (n > limit) ? limit : n;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v >= cnt_t'(ERR_SAT)) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pkt_test_sequencer_rsp.sv
// Response and error bookkeeping for one test: counts completions up to n and
// scores error completions and surplus completions as errors.
module pkt_rsp_tracker
    import pkt_test_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic rsp_valid,
    input  logic rsp_err,
    input  cnt_t n,
    input  logic count_en,
    output cnt_t rsp_cnt,
    output cnt_t err_cnt,
    output logic all_rsp
);

    logic rsp_fire;
    logic spurious;
    logic err_hit;

    assign rsp_fire = count_en & rsp_valid;
    assign all_rsp  = (rsp_cnt == n);
    // A completion beyond the n expected is still one error, even if it also flags rsp_err.
    assign spurious = rsp_fire & all_rsp;
    assign err_hit  = spurious | (rsp_fire & rsp_err);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rsp_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (rsp_fire && !all_rsp) begin
                rsp_cnt <= rsp_cnt + 1'b1;
            end
            if (err_hit) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: rtl/pkt_test_sequencer.sv
// Runs NUM_TESTS packet tests back to back: fetch a count, issue that many
// packets, wait for every completion, then report the error tally.
//
// state  | meaning
// IDLE   | after reset, waiting for start_i
// LOAD   | request and latch the packet count for the next test
// ISSUE  | present packets 0..n-1 with valid/ready handshake
// DRAIN  | all packets issued, waiting for the remaining completions
// REPORT | one-cycle test_done_o pulse with the error count
// DONE   | run finished, results held until start_i
module pkt_test_sequencer
    import pkt_test_sequencer_pkg::*;
#(
    parameter int NUM_TESTS = 3,
    parameter int MAX_PKT   = MAX_PKT_DEF,
    parameter int ID_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [8:0]      n_pkt_i,
    output logic            n_pkt_req_o,
    output logic            pkt_valid_o,
    input  logic            pkt_ready_i,
    output logic [ID_W-1:0] pkt_id_o,
    input  logic            rsp_valid_i,
    input  logic            rsp_err_i,
    output logic [7:0]      test_num_o,
    output logic            test_done_o,
    output logic [8:0]      test_err_cnt_o,
    output logic            busy_o,
    output logic            all_done_o
);

    localparam logic [2:0] ST_IDLE   = S_IDLE;
    localparam logic [2:0] ST_LOAD   = S_LOAD;
    localparam logic [2:0] ST_ISSUE  = S_ISSUE;
    localparam logic [2:0] ST_DRAIN  = S_DRAIN;
    localparam logic [2:0] ST_REPORT = S_REPORT;
    localparam logic [2:0] ST_DONE   = S_DONE;

    logic [2:0] state;
    logic [2:0] state_nxt;
    cnt_t       n_lat;
    cnt_t       iss_cnt;
    cnt_t       n_clamped;
    cnt_t       rsp_cnt;
    cnt_t       err_cnt;
    logic       all_rsp;
    logic       hs;
    logic       last_hs;
    logic       drain_exit;
    logic       idle_like;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign n_clamped = clamp_cnt(n_pkt_i, cnt_t'(MAX_PKT));
    assign hs        = pkt_valid_o & pkt_ready_i;
    assign last_hs   = hs && ((iss_cnt + 1'b1) == n_lat);
    // Every issued packet answered; on entry with all completions in, this holds immediately.
    assign drain_exit = all_rsp && (rsp_cnt == iss_cnt);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start_i) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = (n_clamped == '0) ? ST_REPORT : ST_ISSUE;
            ST_ISSUE:  if (last_hs) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (drain_exit) state_nxt = ST_REPORT;
            ST_REPORT: state_nxt = (test_num_o == 8'(NUM_TESTS)) ? ST_DONE : ST_LOAD;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            test_num_o <= '0;
            n_lat      <= '0;
            iss_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (idle_like && start_i) begin
                test_num_o <= '0;
            end
            if (state == ST_LOAD) begin
                test_num_o <= test_num_o + 1'b1;
                n_lat      <= n_clamped;
                iss_cnt    <= '0;
            end
            if (hs) begin
                iss_cnt <= iss_cnt + 1'b1;
            end
        end
    end

    pkt_rsp_tracker u_rsp (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == ST_LOAD),
        .rsp_valid (rsp_valid_i),
        .rsp_err   (rsp_err_i),
        .n         (n_lat),
        .count_en  ((state == ST_ISSUE) || (state == ST_DRAIN)),
        .rsp_cnt   (rsp_cnt),
        .err_cnt   (err_cnt),
        .all_rsp   (all_rsp)
    );

    assign n_pkt_req_o    = (state == ST_LOAD);
    assign pkt_valid_o    = (state == ST_ISSUE);
    assign pkt_id_o       = pkt_valid_o ? ID_W'(iss_cnt) : '0;
    assign test_done_o    = (state == ST_REPORT);
    assign test_err_cnt_o = err_cnt;
    assign busy_o         = !idle_like;
    assign all_done_o     = (state == ST_DONE);

endmodule

// File: tb/tb_pkt_test_sequencer.sv
// Randomised and directed bench for pkt_test_sequencer with a per-test
// behavioural model of packet ids, handshakes and the expected error tally.
module tb_pkt_test_sequencer;

    logic       clk = 1'b0;
    logic       rst, start_i, pkt_ready_i, rsp_valid_i, rsp_err_i;
    logic [8:0] n_pkt_i;
    logic       n_pkt_req_o, pkt_valid_o, test_done_o, busy_o, all_done_o;
    logic [7:0] pkt_id_o, test_num_o;
    logic [8:0] test_err_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pkt_test_sequencer #(.NUM_TESTS(3), .MAX_PKT(256), .ID_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .n_pkt_i(n_pkt_i),
        .n_pkt_req_o(n_pkt_req_o), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
        .pkt_id_o(pkt_id_o), .rsp_valid_i(rsp_valid_i), .rsp_err_i(rsp_err_i),
        .test_num_o(test_num_o), .test_done_o(test_done_o), .test_err_cnt_o(test_err_cnt_o),
        .busy_o(busy_o), .all_done_o(all_done_o)
    );

    // model state for the test in progress
    int cnt_q[$];
    int cur_n, hs, exp_id, id_bad, pending, rsp_sent, err_model, flood;
    int rdy_pct, rsp_pct, err_pct, err_idx;
    int stall_id, stall_left, stall_seen;
    int req_cnt, valid_cnt, cyc, req_cyc;
    int d_err[$], d_tnum[$], d_hs[$], d_exp_err[$], d_n[$], d_valid[$], d_lat[$];
    bit start_req, saw_all_done;

    task automatic clear_model();
        cnt_q.delete(); d_err.delete(); d_tnum.delete(); d_hs.delete();
        d_exp_err.delete(); d_n.delete(); d_valid.delete(); d_lat.delete();
        cur_n = 0; hs = 0; exp_id = 0; id_bad = 0; pending = 0; rsp_sent = 0;
        err_model = 0; flood = 0; rdy_pct = 100; rsp_pct = 100; err_pct = 0;
        err_idx = -1; stall_id = -1; stall_left = 0; stall_seen = 0;
        req_cnt = 0; valid_cnt = 0; start_req = 0;
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic step();
        int c;
        bit e;
        @(negedge clk);
        cyc++;
        saw_all_done = all_done_o;
        start_i = start_req;
        start_req = 0;
        pkt_ready_i = 0; rsp_valid_i = 0; rsp_err_i = 0;
        if (n_pkt_req_o) begin
            c = (cnt_q.size() > 0) ? cnt_q.pop_front() : 0;
            n_pkt_i = 9'(c);
            cur_n = (c > 256) ? 256 : c;
            hs = 0; exp_id = 0; pending = 0; rsp_sent = 0; err_model = 0; valid_cnt = 0;
            req_cnt++;
            req_cyc = cyc;
        end
        if (pkt_valid_o) begin
            valid_cnt++;
            if (pkt_id_o !== 8'(exp_id)) id_bad++;
            if (exp_id == stall_id) stall_seen++;
            if (exp_id == stall_id && stall_left > 0) stall_left--;
            else if (int'($urandom_range(99)) < rdy_pct) begin
                pkt_ready_i = 1; hs++; exp_id++; pending++;
            end
        end
        if (test_done_o) begin
            d_err.push_back(int'(test_err_cnt_o));
            d_tnum.push_back(int'(test_num_o));
            d_hs.push_back(hs);
            d_n.push_back(cur_n);
            d_valid.push_back(valid_cnt);
            d_lat.push_back(cyc - req_cyc);
            d_exp_err.push_back(err_model > 511 ? 511 : err_model);
        end
        // busy and neither LOAD nor REPORT means ISSUE or DRAIN, where completions count
        if (busy_o && !n_pkt_req_o && !test_done_o && (pending > 0 || flood > 0)
                && int'($urandom_range(99)) < rsp_pct) begin
            rsp_valid_i = 1;
            e = (err_idx >= 0) ? (rsp_sent == err_idx) : (int'($urandom_range(99)) < err_pct);
            rsp_err_i = e;
            if (pending > 0) pending--; else flood--;
            err_model += (rsp_sent < cur_n) ? int'(e) : 1;
            rsp_sent++;
        end
    endtask

    task automatic run_until_done(input int budget, output bit to);
        to = 1;
        start_req = 1;
        step();
        for (int i = 0; i < budget; i++) begin
            step();
            if (saw_all_done) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; start_i = 0; n_pkt_i = 0; pkt_ready_i = 0; rsp_valid_i = 0; rsp_err_i = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({n_pkt_req_o, pkt_valid_o, test_done_o, busy_o, all_done_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {n_pkt_req_o, pkt_valid_o, test_done_o, busy_o, all_done_o});
        end
        checks++;
        if (pkt_id_o !== 8'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", pkt_id_o); end
        checks++;
        if (test_num_o !== 8'd0) begin errors++; $display("FAIL reset_tnum: got %0d expected 0", test_num_o); end
        checks++;
        if (test_err_cnt_o !== 9'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", test_err_cnt_o); end
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_priority: busy %0b expected 0", busy_o); end
        rst = 0;
    endtask

    task automatic test_basic_run();
        bit to;
        clear_model();
        cnt_q = '{5, 1, 256};
        run_until_done(3000, to);
        checks++;
        if (to || d_tnum.size() != 3) begin
            errors++; $display("FAIL basic_dones: got %0d expected 3 (timeout %0b)", d_tnum.size(), to);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (d_tnum[i] != i + 1 || d_err[i] != 0 || d_hs[i] != d_n[i]) begin
                    errors++;
                    $display("FAIL basic_test%0d: tnum %0d err %0d hs %0d expected tnum %0d err 0 hs %0d",
                             i, d_tnum[i], d_err[i], d_hs[i], i + 1, d_n[i]);
                end
            end
        end
        checks++;
        if (id_bad != 0) begin errors++; $display("FAIL basic_ids: %0d bad ids expected 0", id_bad); end
        checks++;
        if (all_done_o !== 1'b1) begin errors++; $display("FAIL basic_all_done: got %0b expected 1", all_done_o); end
    endtask

    task automatic test_stall();
        bit to;
        clear_model();
        cnt_q = '{4, 1, 1};
        stall_id = 2; stall_left = 3;
        run_until_done(500, to);
        checks++;
        if (to || d_hs.size() != 3) begin
            errors++; $display("FAIL stall_dones: got %0d expected 3", d_hs.size());
        end else begin
            checks++;
            if (d_hs[0] != 4 || d_valid[0] != 7) begin
                errors++; $display("FAIL stall_hs: hs %0d valid cycles %0d expected 4 and 7", d_hs[0], d_valid[0]);
            end
        end
        checks++;
        if (stall_seen != 4 || id_bad != 0) begin
            errors++; $display("FAIL stall_hold: id2 cycles %0d bad ids %0d expected 4 and 0", stall_seen, id_bad);
        end
    endtask

    task automatic test_errors();
        bit to;
        clear_model();
        cnt_q = '{3, 1, 1};
        err_idx = 1; flood = 1;
        run_until_done(500, to);
        checks++;
        if (to || d_err.size() != 3) begin
            errors++; $display("FAIL err_dones: got %0d expected 3", d_err.size());
        end else begin
            checks++;
            if (d_err[0] != 2 || d_exp_err[0] != 2) begin
                errors++; $display("FAIL err_count: got %0d model %0d expected 2", d_err[0], d_exp_err[0]);
            end
            checks++;
            if (d_err[1] != 0 || d_err[2] != 0) begin
                errors++; $display("FAIL err_later: got %0d %0d expected 0 0", d_err[1], d_err[2]);
            end
        end
    endtask

    task automatic test_zero_clamp();
        bit to;
        clear_model();
        cnt_q = '{0, 300, 2};
        rdy_pct = 70; rsp_pct = 60;
        run_until_done(4000, to);
        checks++;
        if (to || d_hs.size() != 3) begin
            errors++; $display("FAIL zc_dones: got %0d expected 3", d_hs.size());
        end else begin
            checks++;
            if (d_valid[0] != 0 || d_lat[0] != 1 || d_err[0] != 0) begin
                errors++; $display("FAIL zero_test: valid %0d latency %0d err %0d expected 0 1 0",
                                   d_valid[0], d_lat[0], d_err[0]);
            end
            checks++;
            if (d_hs[1] != 256) begin errors++; $display("FAIL clamp_hs: got %0d expected 256", d_hs[1]); end
        end
        checks++;
        if (id_bad != 0) begin errors++; $display("FAIL zc_ids: %0d bad ids expected 0", id_bad); end
    endtask

    task automatic test_saturation();
        bit to;
        clear_model();
        cnt_q = '{256, 1, 1};
        rdy_pct = 0; err_pct = 100; flood = 600;
        start_req = 1;
        repeat (700) step();
        rdy_pct = 100;
        for (int i = 0; i < 3000 && !saw_all_done; i++) step();
        checks++;
        if (!saw_all_done || d_err.size() != 3) begin
            errors++; $display("FAIL sat_dones: got %0d expected 3", d_err.size());
        end else begin
            checks++;
            if (d_err[0] != 511 || d_exp_err[0] != 511) begin
                errors++; $display("FAIL sat_err: got %0d model %0d expected 511", d_err[0], d_exp_err[0]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int r = 0; r < 4; r++) begin
            clear_model();
            for (int t = 0; t < 3; t++)
                cnt_q.push_back(($urandom_range(7) == 0) ? int'($urandom_range(300, 250))
                                                         : int'($urandom_range(40)));
            rdy_pct = int'($urandom_range(100, 30));
            rsp_pct = int'($urandom_range(100, 30));
            err_pct = int'($urandom_range(50));
            flood = int'($urandom_range(3));
            run_until_done(6000, to);
            checks++;
            if (to || d_err.size() != 3) begin
                errors++; $display("FAIL rand%0d_dones: got %0d expected 3", r, d_err.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (d_err[i] != d_exp_err[i] || d_hs[i] != d_n[i] || d_tnum[i] != i + 1) begin
                        errors++;
                        $display("FAIL rand%0d_test%0d: err %0d hs %0d tnum %0d expected %0d %0d %0d",
                                 r, i, d_err[i], d_hs[i], d_tnum[i], d_exp_err[i], d_n[i], i + 1);
                    end
                end
            end
            checks++;
            if (id_bad != 0) begin errors++; $display("FAIL rand%0d_ids: %0d bad ids expected 0", r, id_bad); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit hit = 0;
        clear_model();
        cnt_q = '{20, 1, 1};
        start_req = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (pkt_valid_o && pkt_id_o == 8'd10) begin
                hit = 1;
                break;
            end
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (!hit || {n_pkt_req_o, pkt_valid_o, test_done_o, busy_o, all_done_o} !== 5'b0
                 || pkt_id_o !== 8'd0 || test_num_o !== 8'd0 || test_err_cnt_o !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset: reached %0b flags %b id %0d tnum %0d err %0d expected 1 00000 0 0 0", hit,
                     {n_pkt_req_o, pkt_valid_o, test_done_o, busy_o, all_done_o}, pkt_id_o, test_num_o, test_err_cnt_o);
        end
        rst = 0;
        clear_model();
        cnt_q = '{2, 1, 1};
        run_until_done(500, to);
        checks++;
        if (to || d_tnum.size() != 3 || d_tnum[0] != 1) begin
            errors++; $display("FAIL mid_restart: dones %0d first tnum %0d expected 3 and 1",
                               d_tnum.size(), (d_tnum.size() > 0) ? d_tnum[0] : -1);
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        bit found = 0;
        clear_model();
        cnt_q = '{2, 1, 1};
        rsp_pct = 0;
        start_req = 1;
        step();
        for (int i = 0; i < 50; i++) begin
            step();
            if (busy_o && !pkt_valid_o && !n_pkt_req_o && !test_done_o && hs == cur_n && cur_n > 0) begin
                found = 1;
                break;
            end
        end
        start_i = 1;
        step();
        checks++;
        if (!found || !busy_o || n_pkt_req_o || test_num_o !== 8'd1) begin
            errors++; $display("FAIL drain_start: drain %0b busy %0b req %0b tnum %0d expected 1 1 0 1",
                               found, busy_o, n_pkt_req_o, test_num_o);
        end
        rsp_pct = 100;
        for (int i = 0; i < 500 && !saw_all_done; i++) step();
        checks++;
        if (!saw_all_done || req_cnt != 3 || d_tnum.size() != 3 || d_tnum[2] != 3) begin
            errors++; $display("FAIL drain_run: done %0b requests %0d dones %0d expected 1 3 3",
                               saw_all_done, req_cnt, d_tnum.size());
        end
        start_req = 1;
        step();
        step();
        checks++;
        if (req_cnt != 4 || all_done_o !== 1'b0 || test_num_o !== 8'd0) begin
            errors++; $display("FAIL done_restart: requests %0d all_done %0b tnum %0d expected 4 0 0",
                               req_cnt, all_done_o, test_num_o);
        end
        for (int i = 0; i < 100 && !all_done_o; i++) step();
    endtask

    initial begin
        cyc = 0;
        clear_model();
        test_reset();
        test_basic_run();
        test_stall();
        test_errors();
        test_zero_clamp();
        test_saturation();
        test_random();
        test_reset_mid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_test_sequencer.md
PKT_TEST_SEQUENCER -- requirements
Module: pkt_test_sequencer

Interface
REQ-001 SHALL have parameters: NUM_TESTS, default 3, number of test iterations per run; MAX_PKT, default 256, upper packet-count clamp; ID_W, default 8, packet index width.
REQ-002 SHALL have ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start_i  in  1  begin a run; honoured only in IDLE or DONE.
n_pkt_i  in  9  packet count for the next test; sampled in LOAD.
n_pkt_req_o  out  1  one-cycle pulse in LOAD; requests the next count.
pkt_valid_o  out  1  packet issue valid.
pkt_ready_i  in  1  DUT accepts the packet when valid&ready.
pkt_id_o  out  ID_W  index of the packet being issued, 0..n-1.
rsp_valid_i  in  1  DUT completion, one per packet.
rsp_err_i  in  1  completion carries an error; qualified by rsp_valid_i.
test_num_o  out  8  current test number, 1-based.
test_done_o  out  1  one-cycle pulse in REPORT.
test_err_cnt_o  out  9  errors in the finished test; valid with test_done_o.
busy_o  out  1  high in every state except IDLE and DONE.
all_done_o  out  1  high while in DONE.

Function
REQ-003 SHALL implement the FSM IDLE, LOAD, ISSUE, DRAIN, REPORT, DONE.
REQ-004 IDLE/DONE + start_i: SHALL go to LOAD next cycle, clear test_num to 0 and deassert all_done_o.
REQ-005 LOAD (1 cycle): SHALL pulse n_pkt_req_o, increment test_num_o, latch n = min(n_pkt_i, MAX_PKT), and clear the issue, response and error counters.
REQ-006 LOAD with n==0: SHALL go directly to REPORT with test_err_cnt_o=0; otherwise SHALL go to ISSUE.
REQ-007 ISSUE: SHALL hold pkt_valid_o=1 with pkt_id_o equal to the issue count; pkt_valid_o and pkt_id_o SHALL stay stable until valid&ready.
REQ-008 On each handshake the issue count SHALL increment; on the n-th handshake pkt_valid_o SHALL drop next cycle and the FSM SHALL go to DRAIN.
REQ-009 Responses SHALL be counted in ISSUE and DRAIN, including a response in the same cycle as a handshake.
REQ-010 DRAIN: SHALL go to REPORT in the cycle after the response count reaches n; if it already equals n on entry, SHALL leave DRAIN after exactly one cycle.
REQ-011 Error count SHALL increment on rsp_valid_i&rsp_err_i.
REQ-012 A spurious response (rsp_valid_i when response count==n, or in any state other than ISSUE/DRAIN) SHALL count as one error when in ISSUE/DRAIN, and SHALL be ignored in other states.
REQ-013 Error count SHALL saturate at 511.
REQ-014 REPORT (1 cycle): SHALL pulse test_done_o with test_err_cnt_o; SHALL go to DONE if test_num_o==NUM_TESTS, else to LOAD.
REQ-015 DONE: SHALL hold all_done_o=1 and test_num_o/test_err_cnt_o unchanged until start_i.
REQ-016 start_i outside IDLE/DONE SHALL be ignored.
REQ-017 Boundary case n=256: pkt_id_o SHALL take the values 0..255 with no wrap before the final handshake.

Reset
REQ-018 rst SHALL take priority over all inputs, including mid-test, and return the FSM to IDLE within one cycle.
REQ-019 Every output SHALL be 0 after reset; all counters and latched n SHALL be 0.

Structure
REQ-020 A shared package SHALL hold the state enum, the 9-bit count typedef and the constants MAX_PKT_DEF=256 and ERR_SAT=511.
REQ-021 Response and error counting SHALL live in one sub-module, pkt_rsp_tracker (clear, rsp_valid, rsp_err, n, count_en -> rsp_cnt, err_cnt, all_rsp).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- NUM_TESTS=3; n_pkt_i 5, 1, 256; ready always 1; one error-free response per packet -> three test_done pulses, test_num_o 1..3, err 0, 0, 0, then all_done_o=1.
- n=4 with ready low for 3 cycles on packet 2 -> pkt_id_o holds 2 with valid high throughout; exactly 4 handshakes.
- n=3 with rsp_err_i on the 2nd response plus one extra response in DRAIN -> test_err_cnt_o=2.
- n_pkt_i=0 -> LOAD then REPORT, no pkt_valid_o, err 0; n_pkt_i=300 -> exactly 256 packets issued.
- rst asserted in ISSUE at packet 10 -> IDLE with all outputs 0 next cycle; start_i then restarts at test_num_o=1.
- start_i pulsed during DRAIN -> no effect; start_i in DONE -> new run with n_pkt_req_o pulse.
